// File: rtl/branch_predict_unit_pkg.sv
// Shared types and constants for the branch predict unit: condition classes,
// MIPS branch opcodes and 2-bit saturating counter states.
package branch_predict_unit_pkg;

  typedef enum logic [2:0] {
    COND_BEQ  = 3'd0,
    COND_BNE  = 3'd1,
    COND_BGTZ = 3'd2,
    COND_BLEZ = 3'd3,
    COND_BLTZ = 3'd4,
    COND_BGEZ = 3'd5
  } cond_t;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  // Saturating step of a 2-bit predictor counter toward the resolved outcome.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_pht.sv
// Pattern history table: 2^PHT_IDX_W saturating counters with one async read
// port and one training port; synchronous reset loads every entry at once.
module bpu_pht
  import branch_predict_unit_pkg::*;
#(
  parameter int         PHT_IDX_W = 6,
  parameter logic [1:0] CNT_INIT  = CTR_WNT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PHT_IDX_W-1:0] rd_idx,
  output logic [1:0]           rd_ctr,
  input  logic                 upd_en,
  input  logic [PHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken
);

  localparam int ENTRIES = 1 << PHT_IDX_W;

  logic [1:0] counters [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) counters[i] <= CNT_INIT;
    end else if (upd_en) begin
      counters[upd_idx] <= ctr_next(counters[upd_idx], upd_taken);
    end
  end

  // Reads see the pre-update value when D and E hit the same entry.
  assign rd_ctr = counters[rd_idx];

endmodule

// File: rtl/branch_predict_unit.sv
// Conditional-branch predictor: predicts in D, resolves and trains in E.
// Optional macro BPU_PERF_CNT_EN adds branch and mispredict counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int         PHT_IDX_W = 6,
  parameter logic [1:0] CNT_INIT  = CTR_WNT,
  parameter int         ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pcD,
  input  logic [31:0]       instrD,
  input  logic [ADDR_W-1:0] targetD,
  input  logic              stallE,
  input  logic              flushE,
  input  logic [31:0]       aE,
  input  logic [31:0]       bE,
  output logic              isBranchD,
  output logic              predTakenD,
  output logic              actualTakenE,
  output logic              mispredictE,
  output logic [ADDR_W-1:0] redirectPcE
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0]       brCount,
  output logic [31:0]       mispCount
`endif
);

  logic [5:0]           op;
  logic                 rt_lsb;
  cond_t                cond_d;
  logic [PHT_IDX_W-1:0] idx_d;
  logic [1:0]           ctr_d;

  logic                 valid_e;
  cond_t                cond_e;
  logic                 pred_e;
  logic [PHT_IDX_W-1:0] idx_e;
  logic [ADDR_W-1:0]    pc_e;
  logic [ADDR_W-1:0]    target_e;
  logic                 cond_true;

  assign op     = instrD[31:26];
  assign rt_lsb = instrD[16];
  assign idx_d  = pcD[PHT_IDX_W+1:2];

  always_comb begin
    isBranchD = 1'b0;
    cond_d    = COND_BEQ;
    case (op)
      OP_BEQ:    begin isBranchD = 1'b1; cond_d = COND_BEQ;  end
      OP_BNE:    begin isBranchD = 1'b1; cond_d = COND_BNE;  end
      OP_BGTZ:   begin isBranchD = 1'b1; cond_d = COND_BGTZ; end
      OP_BLEZ:   begin isBranchD = 1'b1; cond_d = COND_BLEZ; end
      OP_REGIMM: begin isBranchD = 1'b1; cond_d = rt_lsb ? COND_BGEZ : COND_BLTZ; end
      default:   ;
    endcase
  end

  bpu_pht #(
    .PHT_IDX_W(PHT_IDX_W),
    .CNT_INIT (CNT_INIT)
  ) u_pht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx_d),
    .rd_ctr   (ctr_d),
    .upd_en   (valid_e & ~stallE),
    .upd_idx  (idx_e),
    .upd_taken(cond_true)
  );

  assign predTakenD = isBranchD & ctr_d[1];

  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      valid_e  <= 1'b0;
      cond_e   <= COND_BEQ;
      pred_e   <= 1'b0;
      idx_e    <= '0;
      pc_e     <= '0;
      target_e <= '0;
    end else if (!stallE) begin
      valid_e  <= isBranchD;
      cond_e   <= cond_d;
      pred_e   <= predTakenD;
      idx_e    <= idx_d;
      pc_e     <= pcD;
      target_e <= targetD;
    end
  end

  always_comb begin
    cond_true = 1'b0;
    case (cond_e)
      COND_BEQ:  cond_true = (aE == bE);
      COND_BNE:  cond_true = (aE != bE);
      COND_BGTZ: cond_true = ($signed(aE) > 0);
      COND_BLEZ: cond_true = ($signed(aE) <= 0);
      COND_BLTZ: cond_true = ($signed(aE) < 0);
      COND_BGEZ: cond_true = ($signed(aE) >= 0);
      default:   cond_true = 1'b0;
    endcase
  end

  assign actualTakenE = valid_e & cond_true;
  assign mispredictE  = valid_e & (actualTakenE != pred_e);
  // Not-taken fall-through skips the delay slot.
  assign redirectPcE  = actualTakenE ? target_e : pc_e + ADDR_W'(8);

`ifdef BPU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      brCount   <= '0;
      mispCount <= '0;
    end else begin
      if (valid_e && !stallE)     brCount   <= brCount + 32'd1;
      if (mispredictE && !stallE) mispCount <= mispCount + 32'd1;
    end
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{pcD[1:0], pcD[ADDR_W-1:PHT_IDX_W+2], instrD[25:17],
                         instrD[15:0], ctr_d[0]};

endmodule
